note_synth: RTL and testbench

NOTE_SYNTH -- requirements
Module: note_synth

---
 rtl/note_pkg.sv | 43 ++++
 rtl/note_synth_if.sv | 35 +++
 rtl/note_rom.sv | 44 ++++
 rtl/note_synth.sv | 119 +++++++++++
 tb/tb_note_synth.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Note codes and 100 MHz half-period table shared by note_synth.
// Revision    : 1.0 - initial release
// ============================================================================
package note_pkg;

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_CS4  = 4'd2,
        NOTE_D4   = 4'd3,
        NOTE_DS4  = 4'd4,
        NOTE_E4   = 4'd5,
        NOTE_F4   = 4'd6,
        NOTE_FS4  = 4'd7,
        NOTE_G4   = 4'd8,
        NOTE_GS4  = 4'd9,
        NOTE_A4   = 4'd10,
        NOTE_AS4  = 4'd11,
        NOTE_B4   = 4'd12
    } note_e;

    localparam int unsigned NOTE_COUNT = 12;

    // Half-period in 100 MHz cycles, i.e. round(50e6 / f), for codes 1..12.
    localparam int unsigned HALF_PERIOD_TABLE [NOTE_COUNT] = '{
        191113, 180388, 170262, 160706, 151686, 143173,
        135137, 127553, 120394, 113636, 107258, 101238
    };

    function automatic int unsigned note_half_period(input logic [3:0] code);
        int unsigned hp;
        hp = 0;
        if ((code != NOTE_REST) && (code <= NOTE_B4)) begin
            hp = HALF_PERIOD_TABLE[code - 4'd1];
        end
        return hp;
    endfunction

endpackage : note_pkg
`default_nettype wire

// File: rtl/note_synth_if.sv
`default_nettype none
// ============================================================================
// Module      : note_synth_if
// Description : Beat/mute inputs and tone outputs of note_synth.
// Revision    : 1.0 - initial release
// ============================================================================
interface note_synth_if;

    logic [7:0] ibeat;
    logic       beat_tick;
    logic       play_en;
    logic       audio;
    logic [3:0] cur_note;
    logic       sounding;

    modport master (
        output ibeat,
        output beat_tick,
        output play_en,
        input  audio,
        input  cur_note,
        input  sounding
    );

    modport slave (
        input  ibeat,
        input  beat_tick,
        input  play_en,
        output audio,
        output cur_note,
        output sounding
    );

endinterface : note_synth_if
`default_nettype wire

// File: rtl/note_rom.sv
`default_nettype none
// ============================================================================
// Module      : note_rom
// Description : Registered beat-index to note-code lookup (8-bit addr, 4-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
module note_rom
    import note_pkg::*;
(
    input  wire        clk,
    input  wire        rst,
    input  wire        i_en,
    input  wire  [7:0] i_addr,
    output logic [3:0] o_data
);

    logic [3:0] w_data_d;
    logic [3:0] r_data_q;

    always_comb begin
        w_data_d = r_data_q;
        if (i_en) begin
            case (i_addr)
                8'd0:    w_data_d = NOTE_C4;
                8'd1:    w_data_d = NOTE_E4;
                8'd2:    w_data_d = NOTE_G4;
                8'd3:    w_data_d = NOTE_A4;
                default: w_data_d = NOTE_REST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= NOTE_REST;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign o_data = r_data_q;

endmodule : note_rom
`default_nettype wire

// File: rtl/note_synth.sv
`default_nettype none
// ============================================================================
// Module      : note_synth
// Description : Beat-driven square-wave tone generator. Optional articulation
//               gap after every note load is enabled with `define TONE_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module note_synth
    import note_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1024,
    parameter int unsigned CNT_W      = 20
)(
    input  wire         clk,
    input  wire         rst,
    note_synth_if.slave bus
);

    logic [3:0]       w_rom_note;
    logic             w_load_d;
    logic             r_load_q;
    logic [3:0]       w_note_d;
    logic [3:0]       r_note_q;
    logic [CNT_W-1:0] w_half_d;
    logic [CNT_W-1:0] r_half_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic             w_audio_d;
    logic             r_audio_q;
    logic             w_gap_active;
    logic             w_sounding;

    note_rom u_note_rom (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.beat_tick),
        .i_addr (bus.ibeat),
        .o_data (w_rom_note)
    );

`ifdef TONE_GAP_EN
    localparam int unsigned c_gap_w = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    logic [c_gap_w-1:0] w_gap_d;
    logic [c_gap_w-1:0] r_gap_q;

    // Every load (re)arms the gap, including one arriving mid-gap.
    always_comb begin
        w_gap_d = r_gap_q;
        if (r_load_q) begin
            w_gap_d = c_gap_w'(GAP_CYCLES);
        end else if (r_gap_q != '0) begin
            w_gap_d = r_gap_q - c_gap_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_q <= '0;
        end else begin
            r_gap_q <= w_gap_d;
        end
    end

    assign w_gap_active = (r_gap_q != '0);
`else
    logic w_unused_gap_cfg;
    assign w_unused_gap_cfg = (GAP_CYCLES != 0);
    assign w_gap_active     = 1'b0;
`endif

    assign w_sounding = bus.play_en && (r_note_q != NOTE_REST) && !w_gap_active;

    // A load always wins and restarts the waveform from a low phase, even for
    // the same note; muting discards the partial period.
    always_comb begin
        w_load_d  = bus.beat_tick;
        w_note_d  = r_note_q;
        w_half_d  = r_half_q;
        w_cnt_d   = r_cnt_q;
        w_audio_d = r_audio_q;
        if (r_load_q) begin
            w_note_d  = w_rom_note;
            w_half_d  = CNT_W'(note_half_period(w_rom_note));
            w_cnt_d   = '0;
            w_audio_d = 1'b0;
        end else if (!w_sounding) begin
            w_cnt_d   = '0;
            w_audio_d = 1'b0;
        end else if (r_cnt_q == (r_half_q - CNT_W'(1))) begin
            w_cnt_d   = '0;
            w_audio_d = ~r_audio_q;
        end else begin
            w_cnt_d   = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_q  <= 1'b0;
            r_note_q  <= NOTE_REST;
            r_half_q  <= '0;
            r_cnt_q   <= '0;
            r_audio_q <= 1'b0;
        end else begin
            r_load_q  <= w_load_d;
            r_note_q  <= w_note_d;
            r_half_q  <= w_half_d;
            r_cnt_q   <= w_cnt_d;
            r_audio_q <= w_audio_d;
        end
    end

    assign bus.audio    = r_audio_q;
    assign bus.cur_note = r_note_q;
    assign bus.sounding = w_sounding;

endmodule : note_synth
`default_nettype wire

// File: tb/tb_note_synth.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_synth
// Description : Directed timing checks plus randomized beats against a
//               behavioural model of note_synth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_synth;

    localparam int HP_C4 = 191113;
    localparam int HP_A4 = 113636;
`ifdef TONE_GAP_EN
    localparam int GAP = 16;
`else
    localparam int GAP = 0;
`endif
    localparam int unsigned GAP_CFG = (GAP == 0) ? 1024 : GAP;

    typedef struct {
        int         due;
        logic [3:0] note;
    } load_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned passed = 0;
    int unsigned total  = 0;

    load_t       pend[$];
    logic [3:0]  m_note;
    int          m_load;
    bit          e_snd;
    bit          r_rst;
    bit          r_tick;
    bit          r_pe;
    logic [7:0]  r_beat;

    note_synth_if bus ();

    note_synth #(
        .GAP_CYCLES (GAP_CFG),
        .CNT_W      (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Beat-to-note rule: beats 0..3 play C4, E4, G4, A4; everything else rests.
    function automatic logic [3:0] beat_note(input logic [7:0] b);
        case (b)
            8'd0:    return 4'd1;
            8'd1:    return 4'd5;
            8'd2:    return 4'd8;
            8'd3:    return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to the drive point (1 time unit after posedge) n cycles later.
    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.ibeat     = '0;
        bus.beat_tick = 1'b0;
        bus.play_en   = 1'b0;
        skip(3);
        smp();
        check("rst_audio",    bus.audio,    0);
        check("rst_note",     bus.cur_note, 0);
        check("rst_sounding", bus.sounding, 0);

        // A4: load at T+2, rise at T+2+GAP+HP, rise-to-rise of 2*HP
        skip(1); rst = 1'b0; bus.play_en = 1'b1; bus.ibeat = 8'd3; bus.beat_tick = 1'b1;
        smp(); check("a4_t0_note", bus.cur_note, 0);
        skip(1); bus.beat_tick = 1'b0;
        smp(); check("a4_t1_note", bus.cur_note, 0);
        skip(1); smp();
        check("a4_load_note",     bus.cur_note, 10);
        check("a4_load_sounding", bus.sounding, (GAP == 0));
        check("a4_load_audio",    bus.audio,    0);
        skip(GAP + HP_A4 - 1); smp(); check("a4_pre_rise",  bus.audio, 0);
        skip(1);               smp(); check("a4_rise",      bus.audio, 1);
        skip(HP_A4 - 1);       smp(); check("a4_pre_fall",  bus.audio, 1);
        skip(1);               smp(); check("a4_fall",      bus.audio, 0);
        skip(HP_A4 - 1);       smp(); check("a4_pre_rise2", bus.audio, 0);
        skip(1);               smp(); check("a4_rise2",     bus.audio, 1);

        // Reloading the same note restarts with audio low
        skip(1); bus.ibeat = 8'd3; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0;
        smp(); check("reload_hold", bus.audio, 1);
        skip(1); smp();
        check("reload_note",  bus.cur_note, 10);
        check("reload_audio", bus.audio,    0);

        // C4: mute mid-period, unmute restarts a full half-period
        skip(1); bus.ibeat = 8'd0; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0;
        skip(1); smp(); check("c4_load_note", bus.cur_note, 1);
        skip(GAP + 5000); smp();
        check("c4_mid_sounding", bus.sounding, 1);
        check("c4_mid_audio",    bus.audio,    0);
        skip(1); bus.play_en = 1'b0;
        smp(); check("mute_sounding", bus.sounding, 0);
        skip(1); smp();
        check("mute_audio", bus.audio,    0);
        check("mute_note",  bus.cur_note, 1);
        skip(8); bus.play_en = 1'b1;
        smp(); check("unmute_sounding", bus.sounding, 1);
        skip(HP_C4 - 1); smp(); check("c4_pre_rise", bus.audio, 1'b0);
        skip(1);         smp(); check("c4_rise",     bus.audio, 1);
        skip(1); bus.play_en = 1'b0;
        smp();
        check("drop_high_sounding", bus.sounding, 0);
        check("drop_high_same",     bus.audio,    1);
        skip(1); smp(); check("drop_high_next", bus.audio, 0);

        // Loads continue while muted
        skip(1); bus.ibeat = 8'd2; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0;
        skip(1); smp();
        check("muted_load_note",     bus.cur_note, 8);
        check("muted_load_sounding", bus.sounding, 0);
        check("muted_load_audio",    bus.audio,    0);

        // Beat index past the table is a rest
        skip(1); bus.play_en = 1'b1; bus.ibeat = 8'd4; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0;
        skip(1); smp();
        check("rest_note",     bus.cur_note, 0);
        check("rest_sounding", bus.sounding, 0);
        skip(20); smp();
        check("rest_audio",         bus.audio,    0);
        check("rest_sounding_late", bus.sounding, 0);

        // Back-to-back ticks load in order
        skip(1); bus.ibeat = 8'd0; bus.beat_tick = 1'b1;
        skip(1); bus.ibeat = 8'd2;
        skip(1); bus.beat_tick = 1'b0;
        smp(); check("b2b_first", bus.cur_note, 1);
        skip(1); smp(); check("b2b_second", bus.cur_note, 8);

        // Reset one cycle after a tick cancels the load
        skip(1); bus.ibeat = 8'd1; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0; rst = 1'b1;
        smp(); check("rst_mid_prev_note", bus.cur_note, 8);
        skip(1); rst = 1'b0;
        smp();
        check("rst_mid_note",     bus.cur_note, 0);
        check("rst_mid_sounding", bus.sounding, 0);
        check("rst_mid_audio",    bus.audio,    0);
        skip(1); smp(); check("rst_mid_no_load", bus.cur_note, 0);

`ifdef TONE_GAP_EN
        skip(1); bus.ibeat = 8'd0; bus.beat_tick = 1'b1;
        skip(1); bus.beat_tick = 1'b0;
        skip(1);
        for (int k = 0; k < GAP; k++) begin
            smp(); check("gap_sounding", bus.sounding, 0);
            skip(1);
        end
        smp(); check("gap_end_sounding", bus.sounding, 1);
        skip(HP_C4 - 1); smp(); check("gap_pre_rise", bus.audio, 0);
        skip(1);         smp(); check("gap_rise",     bus.audio, 1);
`endif

        // Randomized beats, mutes and resets against the model
        skip(1); rst = 1'b1; bus.beat_tick = 1'b0;
        skip(2); rst = 1'b0;
        r_pe   = 1'b1;
        m_note = 4'd0;
        m_load = -1000000;
        pend.delete();
        for (int t = 0; t < 1500; t++) begin
            r_rst  = ($urandom_range(0, 199) == 0);
            r_tick = ($urandom_range(0, 3) == 0);
            r_beat = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255))
                                                 : 8'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) r_pe = !r_pe;
            rst           = r_rst;
            bus.beat_tick = r_tick;
            bus.ibeat     = r_beat;
            bus.play_en   = r_pe;
            smp();
            while ((pend.size() > 0) && (pend[0].due == t)) begin
                m_note = pend[0].note;
                m_load = t;
                void'(pend.pop_front());
            end
            e_snd = r_pe && (m_note != 4'd0) && ((t - m_load) >= GAP);
            check("rnd_note",     bus.cur_note, m_note);
            check("rnd_sounding", bus.sounding, e_snd);
            // No run in this window is long enough to reach a half-period.
            check("rnd_audio",    bus.audio,    0);
            if (r_rst) begin
                pend.delete();
                m_note = 4'd0;
            end else if (r_tick) begin
                pend.push_back('{due: t + 2, note: beat_note(r_beat)});
            end
            skip(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_note_synth
`default_nettype wire
